// File: rtl/smvm_result_collector.sv
// Result collector for the SMVM core: buffers the unthrottled result stream in a show-ahead
// FIFO, tags each result with its row index and replays it over a valid/ready handshake.
module smvm_result_collector #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ROW_W  = 9,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StDrain   = 2'd2;
    localparam logic [1:0] StFin     = 2'd3;

    localparam int unsigned EntW = ROW_W + DATA_W;
    localparam logic [PTR_W:0] OccFull = (PTR_W + 1)'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [ROW_W-1:0] rows_q, rows_d;
    logic [ROW_W-1:0] in_cnt_q, in_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [1:0]       err_q, err_d;
    logic [EntW-1:0]  mem_q [DEPTH];

    logic [EntW-1:0] head;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push_req;
    logic            push;
    logic            start_acc;

    assign head      = mem_q[rd_ptr_q];
    assign empty     = (occ_q == '0);
    assign full      = (occ_q == OccFull);
    assign pop       = out_valid && out_ready;
    assign push_req  = (state_q == StCollect) && in_valid;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push      = push_req && (!full || pop);
    assign start_acc = (state_q == StIdle) && start;

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        in_cnt_d = in_cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - (PTR_W + 1)'(1);
        end
        // Dropped results still advance the row tag so later rows stay aligned.
        if (push_req) begin
            in_cnt_d = in_cnt_q + ROW_W'(1);
        end

        err_d    = start_acc ? 2'b00 : err_q;
        err_d[0] = err_d[0] | (push_req && !push);
        err_d[1] = err_d[1] | (in_valid && (state_q != StCollect));

        case (state_q)
            StIdle: begin
                if (start) begin
                    rows_d   = num_rows;
                    in_cnt_d = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    occ_d    = '0;
                    state_d  = (num_rows != '0) ? StCollect : StFin;
                end
            end
            StCollect: begin
                if (push_req && (in_cnt_q == rows_q - ROW_W'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The empty check covers a last row that was dropped on overflow.
                if ((pop && out_last) || (empty && (in_cnt_q == rows_q))) begin
                    state_d = StFin;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rows_q   <= '0;
            in_cnt_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            rows_q   <= rows_d;
            in_cnt_q <= in_cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_cnt_q, in_data};
        end
    end

    // Head fields are forced to zero when empty so stale entries never leak out.
    assign out_valid = !empty;
    assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
    assign out_row   = out_valid ? head[EntW-1:DATA_W] : '0;
    assign out_last  = out_valid && (out_row == rows_q - ROW_W'(1));
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);
    assign err       = err_q;

endmodule

// File: tb/tb_smvm_result_collector.sv
// Directed self-checking bench for smvm_result_collector.
module tb_smvm_result_collector;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  num_rows;
    logic        in_valid;
    logic [13:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_data;
    logic [8:0]  out_row;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int total;
    int bad;

    smvm_result_collector #(
        .DATA_W(14),
        .ROW_W (9),
        .DEPTH (8),
        .PTR_W (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_rows (num_rows),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_row  (out_row),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        total++;
        if ({out_valid, out_last, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000", {out_valid, out_last, busy, done});
        end
        total++;
        if (out_data !== 14'h0 || out_row !== 9'h0 || err !== 2'b00) begin
            bad++;
            $display("FAIL reset_vals got data=%h row=%0d err=%b exp 0/0/00",
                     out_data, out_row, err);
        end
    endtask

    task automatic test_basic();
        logic [13:0] vec [3];
        vec[0] = 14'h0011;
        vec[1] = 14'h0022;
        vec[2] = 14'h3FFF;
        out_ready = 1'b1;
        start = 1'b1;
        num_rows = 9'd3;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_start got busy=%b ov=%b exp busy=1 ov=0", busy, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = vec[i];
            tick();
            total++;
            if (out_valid !== 1'b1 || out_row !== 9'(i) || out_data !== vec[i]) begin
                bad++;
                $display("FAIL basic_beat%0d got v=%b row=%0d data=%h exp v=1 row=%0d data=%h",
                         i, out_valid, out_row, out_data, i, vec[i]);
            end
            total++;
            if (out_last !== (i == 2)) begin
                bad++;
                $display("FAIL basic_last%0d got=%b exp=%b", i, out_last, (i == 2));
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0 || err !== 2'b00) begin
            bad++;
            $display("FAIL basic_done got done=%b ov=%b err=%b exp 1/0/00", done, out_valid, err);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_overflow();
        bit got;
        out_ready = 1'b0;
        start = 1'b1;
        num_rows = 9'd12;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data = 14'h0100 + 14'(i);
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (err !== 2'b01) begin
            bad++;
            $display("FAIL ovf_err got=%b exp=01", err);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_row !== 9'd0 || out_data !== 14'h0100 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ovf_hold got v=%b row=%0d data=%h busy=%b exp 1/0/0100/1",
                     out_valid, out_row, out_data, busy);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_row !== 9'(i) || out_data !== 14'h0100 + 14'(i)
                || out_last !== 1'b0) begin
                bad++;
                $display("FAIL ovf_drain%0d got v=%b row=%0d data=%h last=%b exp 1/%0d/%h/0",
                         i, out_valid, out_row, out_data, out_last, i, 14'h0100 + 14'(i));
            end
            tick();
        end
        got = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (got !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ovf_done got done_seen=%b ov=%b exp 1/0", got, out_valid);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ovf_idle got busy=%b exp=0", busy);
        end
    endtask

    // Nine rows: eight fill the FIFO, the ninth arrives together with the first pop.
    task automatic test_full_pop();
        out_ready = 1'b0;
        start = 1'b1;
        num_rows = 9'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = 14'h0200 + 14'(i);
            tick();
        end
        total++;
        if (out_row !== 9'd0 || out_data !== 14'h0200 || err !== 2'b00) begin
            bad++;
            $display("FAIL full_head got row=%0d data=%h err=%b exp 0/0200/00",
                     out_row, out_data, err);
        end
        in_data = 14'h0208;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (err !== 2'b00) begin
            bad++;
            $display("FAIL full_noovf got err=%b exp=00", err);
        end
        for (int i = 1; i < 9; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_row !== 9'(i) || out_data !== 14'h0200 + 14'(i)
                || out_last !== (i == 8)) begin
                bad++;
                $display("FAIL full_beat%0d got v=%b row=%0d data=%h last=%b exp 1/%0d/%h/%b",
                         i, out_valid, out_row, out_data, out_last, i, 14'h0200 + 14'(i),
                         (i == 8));
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || err !== 2'b00) begin
            bad++;
            $display("FAIL full_done got done=%b err=%b exp 1/00", done, err);
        end
        tick();
    endtask

    task automatic test_zero_rows();
        start = 1'b1;
        num_rows = 9'd0;
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_done got done=%b busy=%b ov=%b exp 1/1/0", done, busy, out_valid);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_idle got done=%b busy=%b ov=%b exp 0/0/0", done, busy, out_valid);
        end
    endtask

    task automatic test_idle_err();
        in_valid = 1'b1;
        in_data = 14'h1234;
        tick();
        in_valid = 1'b0;
        total++;
        if (err !== 2'b10 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_err got err=%b ov=%b exp 10/0", err, out_valid);
        end
        out_ready = 1'b1;
        start = 1'b1;
        num_rows = 9'd1;
        tick();
        start = 1'b0;
        total++;
        if (err !== 2'b00) begin
            bad++;
            $display("FAIL idle_clear got err=%b exp=00", err);
        end
        in_valid = 1'b1;
        in_data = 14'h0155;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_row !== 9'd0 || out_data !== 14'h0155
            || out_last !== 1'b1) begin
            bad++;
            $display("FAIL idle_job got v=%b row=%0d data=%h last=%b exp 1/0/0155/1",
                     out_valid, out_row, out_data, out_last);
        end
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL idle_done got=%b exp=1", done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        start = 1'b1;
        num_rows = 9'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = 14'h0300 + 14'(i);
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 14'h0300) begin
            bad++;
            $display("FAIL mid_pre got v=%b data=%h exp 1/0300", out_valid, out_data);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({out_valid, out_last, busy, done} !== 4'b0000 || out_data !== 14'h0
            || out_row !== 9'h0 || err !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset got v/l/b/d=%b data=%h row=%0d err=%b exp all 0",
                     {out_valid, out_last, busy, done}, out_data, out_row, err);
        end
        tick();
        total++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_nodone got done=%b ov=%b exp 0/0", done, out_valid);
        end
        out_ready = 1'b1;
        start = 1'b1;
        num_rows = 9'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 14'h2AAA;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_row !== 9'd0 || out_data !== 14'h2AAA
            || out_last !== 1'b1) begin
            bad++;
            $display("FAIL mid_job got v=%b row=%0d data=%h last=%b exp 1/0/2AAA/1",
                     out_valid, out_row, out_data, out_last);
        end
        tick();
        total++;
        if (done !== 1'b1 || err !== 2'b00) begin
            bad++;
            $display("FAIL mid_done got done=%b err=%b exp 1/00", done, err);
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        num_rows = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_zero_rows();
        test_idle_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
